// File: rtl/scoreboard_cmd_arbiter.sv
// Round-robin arbiter sharing the scoreboard counter's inc/dec port between two requesters.
// Queues one edge-detected command per requester, spaces issues by a hold-off, and derives a clear pulse.
module scoreboard_cmd_arbiter #(
    parameter int unsigned HOLDOFF    = 4,
    parameter int unsigned CLR_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_inc,
    input  logic [1:0] req_dec,
    input  logic       clr_req,
    output logic       inc,
    output logic       dec,
    output logic       clr,
    output logic [1:0] grant,
    output logic [1:0] pend
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CLR_MAX   = CNT_W'(CLR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state, state_nxt;
    logic [1:0]       prev_inc, prev_dec;
    logic [1:0]       op, op_nxt;
    logic [1:0]       pend_nxt;
    logic             rr_ptr, rr_nxt;
    logic             sel, sel_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
    logic             inc_nxt, dec_nxt, clr_nxt;
    logic [1:0]       grant_nxt;

    logic [1:0]       rise_inc, rise_dec;
    logic [1:0]       serve;
    logic             clr_fire;
    logic             pick;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            prev_inc <= 2'b00;
            prev_dec <= 2'b00;
            op       <= 2'b00;
            pend     <= 2'b00;
            rr_ptr   <= 1'b0;
            sel      <= 1'b0;
            hold_cnt <= '0;
            clr_cnt  <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            clr      <= 1'b0;
            grant    <= 2'b00;
        end else begin
            state    <= state_nxt;
            prev_inc <= req_inc;
            prev_dec <= req_dec;
            op       <= op_nxt;
            pend     <= pend_nxt;
            rr_ptr   <= rr_nxt;
            sel      <= sel_nxt;
            hold_cnt <= hold_nxt;
            clr_cnt  <= clr_cnt_nxt;
            inc      <= inc_nxt;
            dec      <= dec_nxt;
            clr      <= clr_nxt;
            grant    <= grant_nxt;
        end
    end

    // Next-state, pending queue, clear detection and output decode
    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        pend_nxt    = pend;
        rr_nxt      = rr_ptr;
        sel_nxt     = sel;
        hold_nxt    = hold_cnt;
        clr_cnt_nxt = clr_cnt;
        inc_nxt     = 1'b0;
        dec_nxt     = 1'b0;
        clr_nxt     = 1'b0;
        grant_nxt   = 2'b00;
        pick        = 1'b0;

        rise_inc = req_inc & ~prev_inc;
        rise_dec = req_dec & ~prev_dec;
        serve    = {(state == S_ISSUE) && sel, (state == S_ISSUE) && !sel};

        if (!clr_req) begin
            clr_cnt_nxt = '0;
        end else if (clr_cnt < CLR_MAX) begin
            clr_cnt_nxt = clr_cnt + CNT_ONE;
        end
        clr_fire = clr_req && (clr_cnt == CLR_MAX - CNT_ONE);

        // A new edge arriving while its requester is being served stays queued
        for (int i = 0; i < 2; i++) begin
            if (serve[i]) begin
                pend_nxt[i] = 1'b0;
            end
            if ((rise_inc[i] ^ rise_dec[i]) && (!pend[i] || serve[i])) begin
                pend_nxt[i] = 1'b1;
                op_nxt[i]   = rise_dec[i];
            end
        end

        case (state)
            S_IDLE: begin
                if ((pend != 2'b00) && !clr_req) begin
                    pick      = (pend == 2'b11) ? rr_ptr : pend[1];
                    state_nxt = S_ISSUE;
                    sel_nxt   = pick;
                    inc_nxt   = ~op[pick];
                    dec_nxt   = op[pick];
                    grant_nxt = {pick, ~pick};
                end
            end
            S_ISSUE: begin
                rr_nxt    = ~sel;
                hold_nxt  = HOLD_LOAD;
                state_nxt = (HOLD_LOAD != '0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (hold_cnt <= CNT_ONE) begin
                    hold_nxt  = '0;
                    state_nxt = S_IDLE;
                end else begin
                    hold_nxt = hold_cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Clear flushes the queue and abandons any hold-off
        if (clr_fire) begin
            clr_nxt   = 1'b1;
            pend_nxt  = 2'b00;
            state_nxt = S_IDLE;
            hold_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_scoreboard_cmd_arbiter.sv
// Bench for scoreboard_cmd_arbiter: directed scenarios plus random traffic, with a queue-based
// reference model predicting every pulse and a monitor that compares what the DUT presents.
module tb_scoreboard_cmd_arbiter;

    localparam int unsigned HOLDOFF    = 4;
    localparam int unsigned CLR_CYCLES = 5;

    logic       clk;
    logic       rst;
    logic [1:0] req_inc;
    logic [1:0] req_dec;
    logic       clr_req;
    logic       inc;
    logic       dec;
    logic       clr;
    logic [1:0] grant;
    logic [1:0] pend;

    int unsigned checks = 0;
    int unsigned errors = 0;

    scoreboard_cmd_arbiter #(
        .HOLDOFF   (HOLDOFF),
        .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_inc(req_inc),
        .req_dec(req_dec),
        .clr_req(clr_req),
        .inc    (inc),
        .dec    (dec),
        .clr    (clr),
        .grant  (grant),
        .pend   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic        inc;
        logic        dec;
        logic        clr;
        logic [1:0]  grant;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state: queued commands, earliest cycle a new grant may start
    int unsigned n;
    logic [1:0]  m_pend, m_op, m_prev_inc, m_prev_dec, m_old;
    logic        m_rr;
    int unsigned m_next_ok;
    int          m_last, m_new_last;
    int unsigned m_run, m_run_old;
    logic        m_fire, m_sel, m_ri, m_rd;
    ev_t         ev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n = 0;
            m_pend = 2'b00; m_op = 2'b00; m_prev_inc = 2'b00; m_prev_dec = 2'b00;
            m_rr = 1'b0; m_next_ok = 0; m_last = -1; m_run = 0;
            exp_q.delete();
        end else begin
            n++;
            m_old     = m_pend;
            m_run_old = m_run;
            m_run     = clr_req ? ((m_run < CLR_CYCLES) ? m_run + 1 : m_run) : 0;
            m_fire    = clr_req && (m_run_old < CLR_CYCLES) && (m_run == CLR_CYCLES);
            m_new_last = -1;
            if (!clr_req && (n >= m_next_ok) && (m_old != 2'b00)) begin
                m_sel = (m_old == 2'b11) ? m_rr : m_old[1];
                ev.cyc = n; ev.clr = 1'b0;
                ev.inc = ~m_op[m_sel]; ev.dec = m_op[m_sel];
                ev.grant = m_sel ? 2'b10 : 2'b01;
                exp_q.push_back(ev);
                m_rr = ~m_sel;
                m_next_ok = n + HOLDOFF + 2;
                m_new_last = m_sel ? 1 : 0;
            end
            if (m_last >= 0) m_pend[m_last] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_ri = req_inc[i] & ~m_prev_inc[i];
                m_rd = req_dec[i] & ~m_prev_dec[i];
                if ((m_ri ^ m_rd) && !m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_op[i]   = m_rd;
                end
            end
            if (m_fire) begin
                m_pend = 2'b00;
                ev.cyc = n; ev.inc = 1'b0; ev.dec = 1'b0; ev.clr = 1'b1; ev.grant = 2'b00;
                exp_q.push_back(ev);
                m_next_ok = n + 1;
            end
            m_last = m_new_last;
            m_prev_inc = req_inc;
            m_prev_dec = req_dec;
        end
    end

    // Monitor: compares DUT pulses and pend against the model after every edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            checks++;
            if ((inc && dec) || (clr && (inc || dec)) || ((inc || dec) != (grant != 2'b00))) begin
                errors++;
                $display("FAIL overlap cyc=%0d inc=%b dec=%b clr=%b grant=%b", n, inc, dec, clr, grant);
            end
            checks++;
            if (pend !== m_pend) begin
                errors++;
                $display("FAIL pend cyc=%0d got=%b exp=%b", n, pend, m_pend);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < n) begin
                checks++;
                errors++;
                $display("FAIL missed cyc=%0d exp_cyc=%0d inc=%b dec=%b clr=%b grant=%b",
                         n, exp_q[0].cyc, exp_q[0].inc, exp_q[0].dec, exp_q[0].clr, exp_q[0].grant);
                void'(exp_q.pop_front());
            end
            if (inc || dec || clr || (grant != 2'b00)) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != n) begin
                    errors++;
                    $display("FAIL unexpected cyc=%0d inc=%b dec=%b clr=%b grant=%b", n, inc, dec, clr, grant);
                end else begin
                    ev = exp_q.pop_front();
                    if (inc !== ev.inc || dec !== ev.dec || clr !== ev.clr || grant !== ev.grant) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d got inc=%b dec=%b clr=%b grant=%b exp inc=%b dec=%b clr=%b grant=%b",
                                 n, inc, dec, clr, grant, ev.inc, ev.dec, ev.clr, ev.grant);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int unsigned cnt_inc, cnt_dec, cnt_clr, burst, clr_at;

    initial begin
        rst = 1'b0; req_inc = 2'b00; req_dec = 2'b00; clr_req = 1'b0;
        #1;
        chk("reset_outputs", {3'b0, inc, dec, clr, grant}, 8'h00);
        chk("reset_pend", {6'b0, pend}, 8'h00);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Two requesters rising together, rr_ptr=0: requester 0 first, requester 1 six cycles later
        @(negedge clk); req_inc = 2'b01; req_dec = 2'b10;
        tick(); tick();
        chk("dual_first", {3'b0, inc, dec, clr, grant}, 8'b0001_0001);
        repeat (5) tick();
        chk("dual_gap_quiet", {3'b0, inc, dec, clr, grant}, 8'h00);
        tick();
        chk("dual_second", {3'b0, inc, dec, clr, grant}, 8'b0000_1010);
        @(negedge clk); req_inc = 2'b00; req_dec = 2'b00;
        repeat (8) tick();

        // Single increment: pulse two edges after the sampled rise, pend drained afterwards
        @(negedge clk); req_inc = 2'b01;
        tick();
        chk("single_pend_set", {6'b0, pend}, 8'h01);
        tick();
        chk("single_inc", {3'b0, inc, dec, clr, grant}, 8'b0001_0001);
        tick();
        chk("single_after", {3'b0, inc, dec, clr, grant}, 8'h00);
        chk("single_pend_clr", {6'b0, pend}, 8'h00);
        @(negedge clk); req_inc = 2'b00;
        repeat (8) tick();

        // Simultaneous inc/dec rise on one requester is discarded; a held level pulses once
        @(negedge clk); req_inc = 2'b10; req_dec = 2'b10;
        cnt_inc = 0; cnt_dec = 0;
        repeat (4) begin tick(); cnt_inc += inc; cnt_dec += dec; end
        chk("both_rise_pend", {6'b0, pend}, 8'h00);
        chk("both_rise_pulses", 8'(cnt_inc + cnt_dec), 8'h00);
        @(negedge clk); req_inc = 2'b00; req_dec = 2'b00;
        tick();
        @(negedge clk); req_inc = 2'b10;
        cnt_inc = 0;
        repeat (20) begin tick(); cnt_inc += inc; end
        chk("held_inc_once", 8'(cnt_inc), 8'h01);
        @(negedge clk); req_inc = 2'b00;
        repeat (4) tick();

        // Short clear request does nothing
        @(negedge clk); clr_req = 1'b1;
        cnt_clr = 0;
        repeat (4) begin tick(); cnt_clr += clr; end
        @(negedge clk); clr_req = 1'b0;
        repeat (3) begin tick(); cnt_clr += clr; end
        chk("clr_short", 8'(cnt_clr), 8'h00);

        // Long clear request: one pulse on the 5th cycle, queued command flushed and never issued
        @(negedge clk); clr_req = 1'b1; req_inc = 2'b01;
        cnt_clr = 0; cnt_inc = 0; clr_at = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            cnt_clr += clr; cnt_inc += inc + dec;
            if (clr) clr_at = c;
        end
        @(negedge clk); clr_req = 1'b0; req_inc = 2'b00;
        repeat (6) begin tick(); cnt_clr += clr; cnt_inc += inc + dec; end
        chk("clr_long_count", 8'(cnt_clr), 8'h01);
        chk("clr_long_cycle", 8'(clr_at), 8'(CLR_CYCLES));
        chk("clr_no_issue", 8'(cnt_inc), 8'h00);
        chk("clr_pend_flushed", {6'b0, pend}, 8'h00);

        // Reset asserted during hold-off with a second command queued
        @(negedge clk); req_inc = 2'b01;
        tick(); tick();
        @(negedge clk); req_dec = 2'b10;
        tick(); tick();
        chk("hold_pend", {6'b0, pend}, 8'h02);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {3'b0, inc, dec, clr, grant}, 8'h00);
        chk("async_rst_pend", {6'b0, pend}, 8'h00);
        @(negedge clk); req_inc = 2'b00; req_dec = 2'b00;
        @(negedge clk); rst = 1'b1;
        repeat (3) tick();

        // Random traffic on both requesters with occasional clear bursts
        burst = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) req_inc[i] = ~req_inc[i];
                if ($urandom_range(0, 4) == 0) req_dec[i] = ~req_dec[i];
            end
            if (burst > 0) begin
                clr_req = 1'b1;
                burst--;
            end else begin
                clr_req = 1'b0;
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(3, 8);
            end
        end
        @(negedge clk); req_inc = 2'b00; req_dec = 2'b00; clr_req = 1'b0;
        repeat (20) tick();
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
